ex_mem_pipe: RTL and testbench

- EX/MEM pipeline register of the 5-stage MIPS core. Sits directly downstream of the ID/EX register and the ALU, and feeds the MEM/WB register.
- Latches ALU result, store data and writeback controls.
- Owns the data-memory request handshake: holds dREN/dWEN until dhit and stalls the pipeline meanwhile.
- Makes halt sticky.

---
 rtl/mux_types_pkg.sv | 20 ++
 rtl/dmem_req_fsm.sv | 81 ++++++++
 rtl/ex_mem_pipe.sv | 120 ++++++++++++
 tb/tb_ex_mem_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_types_pkg.sv
// Shared mux-select and pipeline-state types.
//   rfInMux : register-file write-data source select
//   memst_t : EX/MEM data-memory handshake state, exported so the hazard unit
//             and benches can decode it
package mux_types_pkg;

  typedef enum logic [1:0] {
    RfAlu  = 2'd0,
    RfLoad = 2'd1,
    RfNpc  = 2'd2,
    RfLui  = 2'd3
  } rfInMux;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    WAIT = 2'd1,  // request outstanding, waiting for dhit
    DONE = 2'd2   // request completed while the stage was held
  } memst_t;

endpackage

// File: rtl/dmem_req_fsm.sv
// Data-memory request handshake for the EX/MEM register.
// Decides, every cycle, whether the register bank captures, loads a bubble or
// holds, and drives the memory request / stall lines.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   halt_i                sticky halt from the register bank (freezes contents)
//   en_i, flush_i         advance / bubble requests from the hazard unit
//   req_i                 incoming instruction accesses memory (dREN_i|dWEN_i)
//   dhit_i                memory completion
//   dren_q_i, dwen_q_i    latched request type of the current instruction
//   capture_o, bubble_o   register-bank load controls
//   dREN_o, dWEN_o        memory requests
//   stall_o               memory-wait stall (combinational on dhit_i)
//   state_o               current handshake state
module dmem_req_fsm
  import mux_types_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   halt_i,
  input  logic   en_i,
  input  logic   flush_i,
  input  logic   req_i,
  input  logic   dhit_i,
  input  logic   dren_q_i,
  input  logic   dwen_q_i,
  output logic   capture_o,
  output logic   bubble_o,
  output logic   dREN_o,
  output logic   dWEN_o,
  output logic   stall_o,
  output memst_t state_o
);

  memst_t state_q, state_d;
  logic   flush_pend_q, flush_pend_d;
  logic   wait_st, load, flush_any;

  always_comb begin
    wait_st   = (state_q == WAIT);
    // The stage may only change contents when no transaction is in flight,
    // or on the edge where the outstanding one completes.
    load      = !wait_st || dhit_i;
    flush_any = flush_i || flush_pend_q;
    bubble_o  = load && !halt_i && flush_any;
    capture_o = load && !halt_i && !flush_any && en_i;

    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    if (!load) begin
      // Transaction never aborted: remember the flush for the dhit edge.
      flush_pend_d = flush_pend_q || flush_i;
    end else begin
      flush_pend_d = 1'b0;
      if (bubble_o) begin
        state_d = IDLE;
      end else if (capture_o) begin
        state_d = req_i ? WAIT : IDLE;
      end else if (wait_st) begin
        // Completed while held (or halted): never re-issue.
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign dREN_o  = wait_st && dren_q_i;
  assign dWEN_o  = wait_st && dwen_q_i;
  assign stall_o = wait_st && !dhit_i;
  assign state_o = state_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register of the 5-stage MIPS core.
// Latches the ALU result, store data and writeback controls, owns the
// data-memory request handshake and makes halt sticky.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   en_i, flush_i                  advance enable / bubble insert
//   instr_i, npc_i, aluout_i       instruction, PC+4, ALU result
//   rdat2_i                        store data
//   wsel_i, rfInSel_i, rfWEN_i     writeback controls
//   dREN_i, dWEN_i, halt_i         memory / halt controls
//   dhit_i                         data memory completion
//   instr_o, npc_o, aluout_o       registered copies
//   dmemaddr_o, dmemstore_o        memory address / store data
//   dREN_o, dWEN_o                 memory requests (held until dhit)
//   wsel_o, rfInSel_o, rfWEN_o     registered writeback controls
//   halt_o                         sticky halt
//   stall_o                        memory-wait stall to hazard unit
module ex_mem_pipe
  import mux_types_pkg::*;
#(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned REGSEL_W = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en_i,
  input  logic                flush_i,
  input  logic [WORD_W-1:0]   instr_i,
  input  logic [WORD_W-1:0]   npc_i,
  input  logic [WORD_W-1:0]   aluout_i,
  input  logic [WORD_W-1:0]   rdat2_i,
  input  logic [REGSEL_W-1:0] wsel_i,
  input  rfInMux              rfInSel_i,
  input  logic                rfWEN_i,
  input  logic                dREN_i,
  input  logic                dWEN_i,
  input  logic                halt_i,
  input  logic                dhit_i,
  output logic [WORD_W-1:0]   instr_o,
  output logic [WORD_W-1:0]   npc_o,
  output logic [WORD_W-1:0]   aluout_o,
  output logic [WORD_W-1:0]   dmemaddr_o,
  output logic [WORD_W-1:0]   dmemstore_o,
  output logic                dREN_o,
  output logic                dWEN_o,
  output logic [REGSEL_W-1:0] wsel_o,
  output rfInMux              rfInSel_o,
  output logic                rfWEN_o,
  output logic                halt_o,
  output logic                stall_o
);

  logic [WORD_W-1:0]   instr_q, npc_q, aluout_q, store_q;
  logic [REGSEL_W-1:0] wsel_q;
  rfInMux              rfinsel_q;
  logic                rfwen_q, dren_q, dwen_q, halt_q;
  logic                capture, bubble;
  memst_t              memst;

  dmem_req_fsm u_req_fsm (
    .clk_i     (CLK),
    .rst_i     (RST),
    .halt_i    (halt_q),
    .en_i      (en_i),
    .flush_i   (flush_i),
    .req_i     (dREN_i | dWEN_i),
    .dhit_i    (dhit_i),
    .dren_q_i  (dren_q),
    .dwen_q_i  (dwen_q),
    .capture_o (capture),
    .bubble_o  (bubble),
    .dREN_o    (dREN_o),
    .dWEN_o    (dWEN_o),
    .stall_o   (stall_o),
    .state_o   (memst)
  );

  // Halt never clears except by reset: the FSM masks capture/bubble while
  // halt_q is set, so the whole bank freezes with it.
  always_ff @(posedge CLK) begin
    if (RST || bubble) begin
      instr_q   <= '0;
      npc_q     <= '0;
      aluout_q  <= '0;
      store_q   <= '0;
      wsel_q    <= '0;
      rfinsel_q <= rfInMux'(2'd0);
      rfwen_q   <= 1'b0;
      dren_q    <= 1'b0;
      dwen_q    <= 1'b0;
      halt_q    <= 1'b0;
    end else if (capture) begin
      instr_q   <= instr_i;
      npc_q     <= npc_i;
      aluout_q  <= aluout_i;
      store_q   <= rdat2_i;
      wsel_q    <= wsel_i;
      rfinsel_q <= rfInSel_i;
      rfwen_q   <= rfWEN_i;
      dren_q    <= dREN_i;
      dwen_q    <= dWEN_i;
      halt_q    <= halt_i;
    end
  end

  assign instr_o     = instr_q;
  assign npc_o       = npc_q;
  assign aluout_o    = aluout_q;
  assign dmemaddr_o  = aluout_q;
  assign dmemstore_o = store_q;
  assign wsel_o      = wsel_q;
  assign rfInSel_o   = rfinsel_q;
  assign rfWEN_o     = rfwen_q;
  assign halt_o      = halt_q;

  // State is exported for the hazard unit through the package type only.
  logic unused_memst;
  assign unused_memst = ^memst;

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;
  import mux_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        en_i, flush_i;
  logic [31:0] instr_i, npc_i, aluout_i, rdat2_i;
  logic [4:0]  wsel_i;
  rfInMux      rfInSel_i;
  logic        rfWEN_i, dREN_i, dWEN_i, halt_i, dhit_i;
  logic [31:0] instr_o, npc_o, aluout_o, dmemaddr_o, dmemstore_o;
  logic        dREN_o, dWEN_o;
  logic [4:0]  wsel_o;
  rfInMux      rfInSel_o;
  logic        rfWEN_o, halt_o, stall_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  ex_mem_pipe #(.WORD_W(32), .REGSEL_W(5)) dut (
    .CLK(CLK), .RST(RST), .en_i(en_i), .flush_i(flush_i), .instr_i(instr_i),
    .npc_i(npc_i), .aluout_i(aluout_i), .rdat2_i(rdat2_i), .wsel_i(wsel_i),
    .rfInSel_i(rfInSel_i), .rfWEN_i(rfWEN_i), .dREN_i(dREN_i), .dWEN_i(dWEN_i),
    .halt_i(halt_i), .dhit_i(dhit_i), .instr_o(instr_o), .npc_o(npc_o),
    .aluout_o(aluout_o), .dmemaddr_o(dmemaddr_o), .dmemstore_o(dmemstore_o),
    .dREN_o(dREN_o), .dWEN_o(dWEN_o), .wsel_o(wsel_o), .rfInSel_o(rfInSel_o),
    .rfWEN_o(rfWEN_o), .halt_o(halt_o), .stall_o(stall_o)
  );

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    en_i = 0; flush_i = 0; instr_i = 0; npc_i = 0; aluout_i = 0; rdat2_i = 0;
    wsel_i = 0; rfInSel_i = RfAlu; rfWEN_i = 0; dREN_i = 0; dWEN_i = 0;
    halt_i = 0; dhit_i = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    for (int i = 0; i < 2; i++) begin
      en_i = 1'($urandom); flush_i = 1'($urandom); instr_i = $urandom;
      npc_i = $urandom; aluout_i = $urandom; rdat2_i = $urandom;
      wsel_i = 5'($urandom); rfInSel_i = rfInMux'(2'($urandom));
      rfWEN_i = 1'($urandom); dREN_i = 1; dWEN_i = 1'($urandom);
      halt_i = 1'($urandom); dhit_i = 1'($urandom);
      cyc();
    end
    tests_run++;
    if ({instr_o, npc_o, aluout_o, dmemaddr_o, dmemstore_o} !== 160'd0) begin
      tests_failed++;
      $display("FAIL reset_words got %h %h %h %h %h want all 0", instr_o, npc_o,
               aluout_o, dmemaddr_o, dmemstore_o);
    end
    tests_run++;
    if ({dREN_o, dWEN_o, wsel_o, rfInSel_o, rfWEN_o, halt_o, stall_o} !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_ctl got dREN=%b dWEN=%b wsel=%0d sel=%0d wen=%b halt=%b stall=%b want 0",
               dREN_o, dWEN_o, wsel_o, rfInSel_o, rfWEN_o, halt_o, stall_o);
    end
    idle_inputs();
    RST = 0;
    cyc();
  endtask

  task automatic test_alu();
    idle_inputs();
    en_i = 1; instr_i = 32'h0022_1820; npc_i = 32'h104; aluout_i = 32'h10;
    rdat2_i = 32'h55; wsel_i = 5'd3; rfWEN_i = 1;
    cyc();
    idle_inputs();
    tests_run++;
    if (aluout_o !== 32'h10 || wsel_o !== 5'd3 || rfWEN_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL alu_fields got alu=%h wsel=%0d wen=%b want 10 3 1", aluout_o, wsel_o, rfWEN_o);
    end
    tests_run++;
    if (instr_o !== 32'h0022_1820 || npc_o !== 32'h104 || dmemstore_o !== 32'h55) begin
      tests_failed++;
      $display("FAIL alu_words got instr=%h npc=%h st=%h want 00221820 104 55", instr_o, npc_o,
               dmemstore_o);
    end
    tests_run++;
    if (dREN_o !== 1'b0 || stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_nomem got dREN=%b stall=%b want 0 0", dREN_o, stall_o);
    end
  endtask

  task automatic test_load_wait();
    idle_inputs();
    en_i = 1; instr_i = 32'h8C01_0000; dREN_i = 1; aluout_i = 32'h80; wsel_i = 5'd1;
    rfWEN_i = 1; rfInSel_i = RfLoad;
    cyc();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (dREN_o !== 1'b1 || stall_o !== 1'b1 || dmemaddr_o !== 32'h80) begin
        tests_failed++;
        $display("FAIL load_wait%0d got dREN=%b stall=%b addr=%h want 1 1 80", i, dREN_o, stall_o,
                 dmemaddr_o);
      end
      cyc();
    end
    dhit_i = 1;
    #1;
    tests_run++;
    if (dREN_o !== 1'b1 || stall_o !== 1'b0 || dmemaddr_o !== 32'h80) begin
      tests_failed++;
      $display("FAIL load_hit got dREN=%b stall=%b addr=%h want 1 0 80", dREN_o, stall_o, dmemaddr_o);
    end
    cyc();
    dhit_i = 0;
    #1;
    tests_run++;
    if (dREN_o !== 1'b0 || stall_o !== 1'b0 || dmemaddr_o !== 32'h80 || rfInSel_o !== RfLoad) begin
      tests_failed++;
      $display("FAIL load_after got dREN=%b stall=%b addr=%h sel=%0d want 0 0 80 1", dREN_o,
               stall_o, dmemaddr_o, rfInSel_o);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    en_i = 1; instr_i = 32'h8C02_0004; dREN_i = 1; aluout_i = 32'h84;
    cyc();
    idle_inputs();
    en_i = 1; instr_i = 32'h0043_2020; aluout_i = 32'h7; dhit_i = 1;
    #1;
    tests_run++;
    if (dREN_o !== 1'b1 || stall_o !== 1'b0 || dmemaddr_o !== 32'h84) begin
      tests_failed++;
      $display("FAIL b2b_hit got dREN=%b stall=%b addr=%h want 1 0 84", dREN_o, stall_o, dmemaddr_o);
    end
    cyc();
    idle_inputs();
    tests_run++;
    if (instr_o !== 32'h0043_2020 || aluout_o !== 32'h7 || dREN_o !== 1'b0 || stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_next got instr=%h alu=%h dREN=%b stall=%b want 00432020 7 0 0", instr_o,
               aluout_o, dREN_o, stall_o);
    end
  endtask

  task automatic test_store_flush();
    idle_inputs();
    en_i = 1; instr_i = 32'hAC05_0008; dWEN_i = 1; aluout_i = 32'h88; rdat2_i = 32'hCAFE;
    rfWEN_i = 1;
    cyc();
    idle_inputs();
    tests_run++;
    if (dWEN_o !== 1'b1 || dmemstore_o !== 32'hCAFE || stall_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL st_w1 got dWEN=%b data=%h stall=%b want 1 cafe 1", dWEN_o, dmemstore_o, stall_o);
    end
    cyc();
    flush_i = 1; en_i = 1; instr_i = 32'h1234_5678;
    cyc();
    idle_inputs();
    tests_run++;
    if (dWEN_o !== 1'b1 || instr_o !== 32'hAC05_0008 || stall_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL st_w3 got dWEN=%b instr=%h stall=%b want 1 ac050008 1", dWEN_o, instr_o, stall_o);
    end
    cyc();
    dhit_i = 1;
    #1;
    tests_run++;
    if (dWEN_o !== 1'b1 || stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL st_hit got dWEN=%b stall=%b want 1 0", dWEN_o, stall_o);
    end
    cyc();
    dhit_i = 0;
    tests_run++;
    if (instr_o !== 32'h0 || rfWEN_o !== 1'b0 || dWEN_o !== 1'b0 || aluout_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL st_bubble got instr=%h wen=%b dWEN=%b alu=%h want 0 0 0 0", instr_o, rfWEN_o,
               dWEN_o, aluout_o);
    end
  endtask

  task automatic test_done_hold();
    idle_inputs();
    en_i = 1; instr_i = 32'h8C0A_0010; dREN_i = 1; aluout_i = 32'h90;
    cyc();
    idle_inputs();
    dhit_i = 1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      dhit_i = (i != 1);
      #1;
      tests_run++;
      if (dREN_o !== 1'b0 || stall_o !== 1'b0 || instr_o !== 32'h8C0A_0010) begin
        tests_failed++;
        $display("FAIL done_hold%0d got dREN=%b stall=%b instr=%h want 0 0 8c0a0010", i, dREN_o,
                 stall_o, instr_o);
      end
      cyc();
    end
    idle_inputs();
    en_i = 1; instr_i = 32'h0000_0021; aluout_i = 32'h3;
    cyc();
    idle_inputs();
    tests_run++;
    if (instr_o !== 32'h0000_0021 || aluout_o !== 32'h3 || dREN_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_next got instr=%h alu=%h dREN=%b want 00000021 3 0", instr_o, aluout_o,
               dREN_o);
    end
  endtask

  task automatic test_halt();
    idle_inputs();
    en_i = 1; halt_i = 1; instr_i = 32'hFFFF_FFFF; aluout_i = 32'h44;
    cyc();
    idle_inputs();
    tests_run++;
    if (halt_o !== 1'b1 || instr_o !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL halt_set got halt=%b instr=%h want 1 ffffffff", halt_o, instr_o);
    end
    en_i = 1; flush_i = 1; instr_i = 32'h0101_0101; aluout_i = 32'h99;
    cyc();
    flush_i = 0;
    cyc();
    tests_run++;
    if (halt_o !== 1'b1 || instr_o !== 32'hFFFF_FFFF || aluout_o !== 32'h44) begin
      tests_failed++;
      $display("FAIL halt_frozen got halt=%b instr=%h alu=%h want 1 ffffffff 44", halt_o, instr_o,
               aluout_o);
    end
    idle_inputs();
    RST = 1;
    cyc();
    RST = 0;
    tests_run++;
    if (halt_o !== 1'b0 || instr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL halt_reset got halt=%b instr=%h want 0 0", halt_o, instr_o);
    end
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    #2;
    test_reset();
    test_alu();
    test_load_wait();
    test_back_to_back();
    test_store_flush();
    test_done_hold();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
